// File: rtl/mba_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mba_pkg
// Brief    : Shared types and helpers for the radix-4 Booth sequential multiplier.
// Revision : 1.0
// ============================================================================
package mba_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Booth digit in -2..+2
  typedef logic signed [2:0] booth_digit_t;

  function automatic int num_digits(input int width);
    return width / 2 + 1;
  endfunction

  function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
    case (triplet)
      3'b001, 3'b010: return 3'b001;
      3'b011:         return 3'b010;
      3'b100:         return 3'b110;
      3'b101, 3'b110: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_enc.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_enc
// Brief    : Radix-4 Booth encoder; selects 0, +-1 or +-2 times the signed
//            multiplicand as a PP_W-bit two's complement partial product.
// Revision : 1.0
// ============================================================================
module booth_r4_enc
  import mba_pkg::*;
#(
  parameter int N    = 10,
  parameter int PP_W = N + 1
) (
  input  logic [2:0]      i_triplet,
  input  logic [N-1:0]    i_mcand,
  output logic [PP_W-1:0] o_pp
);

  booth_digit_t    w_digit;
  logic [PP_W-1:0] w_a1;
  logic [PP_W-1:0] w_a2;
  logic [PP_W-1:0] w_mag;

  assign w_digit = booth_decode(i_triplet);
  assign w_a1    = PP_W'($signed(i_mcand));
  assign w_a2    = {w_a1[PP_W-2:0], 1'b0};

  always_comb begin
    w_mag = '0;
    case (w_digit)
      3'b001, 3'b111: w_mag = w_a1;
      3'b010, 3'b110: w_mag = w_a2;
      default:        w_mag = '0;
    endcase
  end

  assign o_pp = w_digit[2] ? -w_mag : w_mag;

endmodule
`default_nettype wire

// File: rtl/mba_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : mba_seq_mult
// Brief    : Iterative radix-4 Modified Booth multiplier, one digit per clock,
//            valid/ready on both sides. Optional MBA_SEQ_EARLY_TERM_EN stops
//            as soon as all remaining Booth digits are zero.
// Revision : 1.0
// ============================================================================
module mba_seq_mult
  import mba_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int c_num_digits = num_digits(WIDTH);
  localparam int c_cnt_w      = $clog2(c_num_digits);
  localparam int c_acc_w      = 2 * WIDTH;
  localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_num_digits - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_acc_w-1:0]   r_mcand;
  logic [c_acc_w-1:0]   r_p;
  logic [c_acc_w-1:0]   w_pp;
  logic [c_acc_w-1:0]   w_sum;
  logic [WIDTH+1:0]     r_mplier;
  logic [WIDTH+1:0]     w_a_ext;
  logic [WIDTH+1:0]     w_b_ext;
  logic                 r_lb;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_accept;
  logic                 w_last;

  assign w_a_ext  = {{2{signed_mode & a[WIDTH-1]}}, a};
  assign w_b_ext  = {{2{signed_mode & b[WIDTH-1]}}, b};
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // Multiplicand is kept at accumulator width so the left shift replaces the 2i weighting.
  booth_r4_enc #(
    .N    (c_acc_w),
    .PP_W (c_acc_w)
  ) u_enc (
    .i_triplet ({r_mplier[1:0], r_lb}),
    .i_mcand   (r_mcand),
    .o_pp      (w_pp)
  );

  assign w_sum = r_acc + w_pp;

`ifdef MBA_SEQ_EARLY_TERM_EN
  // Arithmetic shift fills with the sign, so the upper bits cover every unexamined bit.
  assign w_last = (r_cnt == c_last_digit) ||
                  (r_mplier[WIDTH+1:2] == {WIDTH{r_mplier[1]}});
`else
  assign w_last = (r_cnt == c_last_digit);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_lb     <= 1'b0;
      r_cnt    <= '0;
      r_p      <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{(WIDTH-2){w_a_ext[WIDTH+1]}}, w_a_ext};
      r_mplier <= w_b_ext;
      r_lb     <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_sum;
      r_mcand  <= {r_mcand[c_acc_w-3:0], 2'b00};
      r_mplier <= {{2{r_mplier[WIDTH+1]}}, r_mplier[WIDTH+1:2]};
      r_lb     <= r_mplier[1];
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_p <= w_sum;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign p         = r_p;

endmodule
`default_nettype wire
